// File: rtl/sorting_engine.sv
// sorting_engine: in-place early-exit bubble sorter over a DEPTH x W register array.
// One compare-swap per clock, ascending or descending, with a registered read port.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset (clears state, outputs and memory)
//   wr_init_i    write data_in_i to mem[addr_i] (ignored while busy)
//   addr_i       shared read/write address
//   data_in_i    write data
//   rd_i         read request; data_out_o valid the cycle after (ignored while busy)
//   data_out_o   registered read data
//   start_i      single-cycle pulse that begins a sort
//   descend_i    0 = ascending, 1 = descending; sampled on start
//   busy_o       high while a sort is running
//   done_o       sticky completion flag
// Optional (macro SORT_STATS_EN):
//   swap_count_o   saturating count of swaps in the last sort
//   cycle_count_o  saturating count of compare cycles in the last sort
module sorting_engine #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_init_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  data_in_i,
    input  logic          rd_i,
    output logic [W-1:0]  data_out_o,
    input  logic          start_i,
    input  logic          descend_i,
    output logic          busy_o,
`ifdef SORT_STATS_EN
    output logic [15:0]   swap_count_o,
    output logic [15:0]   cycle_count_o,
`endif
    output logic          done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SORT,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    data_q;
    logic [AW-1:0]   j_q;
    logic [AW-1:0]   limit_q;
    logic            ord_q;
    logic            swp_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    cur_c;
    logic [W-1:0]    nxt_c;
    logic            swap_c;
    logic            more_c;
    logic            addr_ok_c;

    // Current compare pair and swap decision; equal values never swap (stable).
    assign cur_c     = mem_q[j_q];
    assign nxt_c     = mem_q[j_q + AW'(1)];
    assign swap_c    = ord_q ? (cur_c < nxt_c) : (cur_c > nxt_c);
    assign more_c    = (j_q < (limit_q - AW'(1)));
    assign addr_ok_c = (32'(addr_i) < DEPTH);

`ifdef SORT_STATS_EN
    logic [15:0] swap_cnt_q;
    logic [15:0] cyc_cnt_q;
    assign swap_count_o  = swap_cnt_q;
    assign cycle_count_o = cyc_cnt_q;
`endif

    // Control FSM, memory array and read port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            j_q     <= '0;
            limit_q <= '0;
            ord_q   <= 1'b0;
            swp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
`ifdef SORT_STATS_EN
            swap_cnt_q <= '0;
            cyc_cnt_q  <= '0;
`endif
        end else begin
            // Read samples the pre-edge array, so a same-address write returns old data.
            if (rd_i && !busy_q) begin
                data_q <= addr_ok_c ? mem_q[addr_i] : '0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (busy_q) begin
                        // First cycle in DONE: retire the sort.
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (wr_init_i) begin
                        if (addr_ok_c) begin
                            mem_q[addr_i] <= data_in_i;
                        end
                        done_q <= 1'b0;
                    end else if (start_i) begin
                        ord_q   <= descend_i;
                        j_q     <= '0;
                        limit_q <= AW'(DEPTH - 1);
                        swp_q   <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (DEPTH == 1) ? ST_DONE : ST_SORT;
`ifdef SORT_STATS_EN
                        swap_cnt_q <= '0;
                        cyc_cnt_q  <= '0;
`endif
                    end
                end

                ST_SORT: begin
                    if (swap_c) begin
                        mem_q[j_q]          <= nxt_c;
                        mem_q[j_q + AW'(1)] <= cur_c;
                        swp_q               <= 1'b1;
                    end
`ifdef SORT_STATS_EN
                    if (swap_c && (swap_cnt_q != 16'hFFFF)) begin
                        swap_cnt_q <= swap_cnt_q + 16'd1;
                    end
                    if (cyc_cnt_q != 16'hFFFF) begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
`endif
                    if (more_c) begin
                        j_q <= j_q + AW'(1);
                    end else if ((swp_q || swap_c) && (limit_q > AW'(1))) begin
                        // Another pass is needed; the last slot of this pass is final.
                        limit_q <= limit_q - AW'(1);
                        j_q     <= '0;
                        swp_q   <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_sorting_engine.sv
// Testbench for sorting_engine: directed and random loads, sorted results and
// latency checked against a queue-based reference model.
module tb_sorting_engine;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_init;
    logic [AW-1:0] addr;
    logic [W-1:0]  data_in;
    logic          rd;
    logic [W-1:0]  data_out;
    logic          start;
    logic          descend;
    logic          busy;
    logic          done;
`ifdef SORT_STATS_EN
    logic [15:0]   swap_count;
    logic [15:0]   cycle_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int vals [DEPTH];
    int lat;

    sorting_engine #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_init_i    (wr_init),
        .addr_i       (addr),
        .data_in_i    (data_in),
        .rd_i         (rd),
        .data_out_o   (data_out),
        .start_i      (start),
        .descend_i    (descend),
        .busy_o       (busy),
`ifdef SORT_STATS_EN
        .swap_count_o (swap_count),
        .cycle_count_o(cycle_count),
`endif
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_init = 1'b1;
        addr    = AW'(a);
        data_in = W'(d);
        @(posedge clk);
        #1;
        wr_init = 1'b0;
    endtask

    task automatic rd_check(input int a, input int exp, input string tag);
        @(negedge clk);
        rd   = 1'b1;
        addr = AW'(a);
        @(posedge clk);
        #1;
        rd = 1'b0;
        check($sformatf("%s[%0d]", tag, a), 32'(data_out), 32'(exp));
    endtask

    task automatic load_vals();
        for (int i = 0; i < int'(DEPTH); i++) wr(i, vals[i]);
    endtask

    // Expected contents: the loaded values in the requested order.
    task automatic check_sorted(input logic desc, input string tag);
        int q[$];
        for (int i = 0; i < int'(DEPTH); i++) q.push_back(vals[i]);
        if (desc) q.rsort(); else q.sort();
        for (int i = 0; i < int'(DEPTH); i++) rd_check(i, q[i], tag);
    endtask

    // Bubble sort performs exactly one swap per inverted pair.
    function automatic int inversions(input logic desc);
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++)
            for (int k = i + 1; k < int'(DEPTH); k++)
                if (desc ? (vals[i] < vals[k]) : (vals[i] > vals[k])) n++;
        return n;
    endfunction

    // Pulse start and count edges until done. poke=1 injects an ignored
    // write/start at edge 3; poke=2 asserts reset for the 5th edge.
    task automatic run_sort(input logic desc, input int poke, output int lat_o);
        bit fin = 0;
        lat_o = -1;
        @(negedge clk);
        start   = 1'b1;
        descend = desc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int n = 1; n <= 200 && !fin; n++) begin
            @(negedge clk);
            if (poke == 1 && n == 3) begin
                wr_init = 1'b1;
                addr    = '0;
                data_in = 8'hFF;
                start   = 1'b1;
                descend = ~desc;
            end
            if (poke == 2 && n == 5) rst_n = 1'b0;
            @(posedge clk);
            #1;
            wr_init = 1'b0;
            start   = 1'b0;
            if (poke == 2 && n == 5) begin
                rst_n = 1'b1;
                lat_o = n;
                fin   = 1;
            end else if (done) begin
                lat_o = n;
                fin   = 1;
            end
        end
        if (!fin) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_init = 1'b0;
        addr    = '0;
        data_in = '0;
        rd      = 1'b0;
        start   = 1'b0;
        descend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        rd_check(3, 0, "reset_mem");

        // Mixed data, ascending then descending.
        vals = '{45, 12, 78, 34, 56, 89, 23, 67};
        load_vals();
        run_sort(1'b0, 0, lat);
        check("mix_asc_done", 32'(done), 32'd1);
        check("mix_asc_busy", 32'(busy), 32'd0);
        check_sorted(1'b0, "mix_asc");
        load_vals();
        run_sort(1'b1, 0, lat);
        check_sorted(1'b1, "mix_desc");

        // Already sorted: one pass, no swaps.
        vals = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_vals();
        run_sort(1'b0, 0, lat);
        check("sorted_latency", 32'(lat), 32'd8);
`ifdef SORT_STATS_EN
        check("sorted_swaps", 32'(swap_count), 32'd0);
        check("sorted_cycles", 32'(cycle_count), 32'd7);
`endif
        check_sorted(1'b0, "sorted");

        // Reverse order: worst case.
        vals = '{8, 7, 6, 5, 4, 3, 2, 1};
        load_vals();
        run_sort(1'b0, 0, lat);
        check("reverse_latency", 32'(lat), 32'd29);
`ifdef SORT_STATS_EN
        check("reverse_swaps", 32'(swap_count), 32'd28);
        check("reverse_cycles", 32'(cycle_count), 32'd28);
`endif
        check_sorted(1'b0, "reverse");

        // Duplicates, with a write and start attempted mid-sort.
        vals = '{5, 3, 5, 1, 3, 1, 5, 3};
        load_vals();
        run_sort(1'b0, 1, lat);
        check("dup_done", 32'(done), 32'd1);
        check_sorted(1'b0, "dup");

        // A write after completion clears done.
        wr(7, 9);
        check("done_cleared_by_write", 32'(done), 32'd0);

        // Reset during a sort zeroes everything.
        vals = '{8, 7, 6, 5, 4, 3, 2, 1};
        load_vals();
        rd_check(0, 8, "pre_reset");
        run_sort(1'b0, 2, lat);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_data_out", 32'(data_out), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) rd_check(i, 0, "midreset_mem");

        // Random loads; narrow value ranges on some rounds force duplicates.
        for (int r = 0; r < 8; r++) begin
            logic desc;
            int   inv;
            int   hi;
            hi   = (r % 2 == 0) ? 255 : 4;
            desc = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(DEPTH); i++) vals[i] = int'($urandom_range(0, hi));
            inv = inversions(desc);
            load_vals();
            run_sort(desc, 0, lat);
            check($sformatf("rand%0d_lat_min", r), 32'(lat >= 8), 32'd1);
            check($sformatf("rand%0d_lat_max", r), 32'(lat <= 29), 32'd1);
            if (inv == 0) check($sformatf("rand%0d_lat_ordered", r), 32'(lat), 32'd8);
`ifdef SORT_STATS_EN
            check($sformatf("rand%0d_swaps", r), 32'(swap_count), 32'(inv));
            check($sformatf("rand%0d_cycles", r), 32'(cycle_count), 32'(lat - 1));
`endif
            check_sorted(desc, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sorting_engine.md
Name: sorting_engine

Overview:
Parametrised in-place sorter, next generation of sorting_top. It holds DEPTH words of W bits in a register array, loaded through a write port. On start it runs an early-exit bubble sort, one compare-swap per cycle, in ascending or descending order. Results are read back through a registered read port. It sits between a host loader/reader and any downstream consumer of sorted data.

Parameters:
W, 8, data width in bits (unsigned compare)
DEPTH, 8, number of entries; legal range 1..2**AW
AW, 3, address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
wr_init  input  1  write data_in to mem[addr] this cycle
addr  input  AW  shared read/write address
data_in  input  W  write data
rd  input  1  read request for mem[addr]
data_out  output  W  registered read data, valid the cycle after rd
start  input  1  single-cycle pulse that begins a sort
descend  input  1  order select: 0 = ascending, 1 = descending; sampled on start
busy  output  1  high while a sort is running
done  output  1  sticky completion flag

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; data_out=0, busy=0, done=0; all mem entries=0; internal counters cleared. Reset mid-sort aborts immediately; memory is zeroed.
- Write: in IDLE or DONE with wr_init=1, mem[addr]<=data_in at the edge. A write clears done. wr_init is ignored while busy. A write with addr>=DEPTH is ignored.
- Read: with rd=1 and not busy, data_out<=mem[addr] at the edge. Read with addr>=DEPTH gives 0. Otherwise data_out holds. rd is ignored while busy.
- Same-cycle wr_init and rd to the same address: data_out gets the old value (read-before-write).
- start with busy=0 and wr_init=0:
  - Latch descend into ord.
  - j<=0, limit<=DEPTH-1, swp<=0.
  - done<=0, busy<=1.
  - Go to SORT, or to DONE directly if DEPTH==1.
- start with wr_init=1 in the same cycle: write happens, start is ignored. start while busy is ignored.
- SORT, one cycle per compare:
  - Compare mem[j] and mem[j+1].
  - Swap when (ord=0 and mem[j]>mem[j+1]) or (ord=1 and mem[j]<mem[j+1]). Equal values never swap, so the sort is stable.
  - Set swp if a swap happens.
  - If j<limit-1: j<=j+1.
  - Else (end of pass): if (swp or swap this cycle) and limit>1, then limit<=limit-1, j<=0, swp<=0. Otherwise go to DONE.
- DONE (entered at the edge after the last compare): busy<=0, done<=1. done stays high until the next accepted start, a write, or reset. The FSM accepts start and wr_init exactly as in IDLE.
- Latency, start edge to done high:
  - Already ordered: DEPTH-1 compare cycles + 1 cycle.
  - Worst case: DEPTH*(DEPTH-1)/2 compare cycles + 1 cycle.
  - DEPTH==1: done at the edge after start.
- FSM states: IDLE, SORT, DONE.

Optional Feature:
SORT_STATS_EN
- Defined: adds output swap_count (16 bits) and output cycle_count (16 bits).
  - Both clear on an accepted start.
  - swap_count increments once per swap; cycle_count increments once per SORT cycle.
  - Both saturate at 16'hFFFF.
  - Both hold their values in DONE; both are 0 after reset.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
- Load 45,12,78,34,56,89,23,67 into addr 0..7, start with descend=0, wait done, read 0..7 -> 12,23,34,45,56,67,78,89.
- Same load, descend=1 -> 89,78,67,56,45,34,23,12.
- Load 1..8 ascending, start with descend=0 -> done high 8 edges after start; contents unchanged; with SORT_STATS_EN: swap_count=0, cycle_count=7.
- Load 8..1, descend=0 -> done 29 edges after start; result 1..8; with SORT_STATS_EN: swap_count=28.
- Load 5,3,5,1,3,1,5,3, descend=0 -> 1,1,3,3,3,5,5,5; a second start pulse and wr_init during busy -> both ignored, memory unaffected.
- Drive rst=0 for one edge 5 cycles into a sort -> busy=0, done=0, data_out=0; reads of addr 0..7 all return 0.
